rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters.
- Produces a 3-bit grant index and its one-hot 8-bit decode, registered.
- Holds each grant until the owner releases it, drops its request, or a hold timeout expires.
- Sits in front of any shared datapath whose select is driven by a 3-to-8 decode of the winning index.

---
 rtl/rr_arbiter_8.sv | 129 ++++++++++++
 tb/tb_rr_arbiter_8.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter sharing one resource among 8 requesters.
// Registered grant index and one-hot grant. The owner keeps the grant until it
// releases, drops its request, or holds it for MAX_HOLD cycles (0 = no limit).
// Every handover passes through one idle cycle.
//
// Handshake: a requester raises req[i] and keeps it high while it wants the
// resource. It owns the resource while grant_valid=1 and grant_idx=i. It ends
// ownership by pulsing release_req for one cycle or by dropping req[i]. A new
// grant is issued only from IDLE, and only when en=1. release_req is ignored
// while grant_valid=0. The owner's release input is named release_req because
// `release` is a reserved word in SystemVerilog.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       release_req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout,
    output logic       state_dbg
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Counter value seen on the last permitted BUSY cycle.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [2:0]       last, last_n;
    logic [2:0]       idx_n;
    logic [7:0]       grant_n;
    logic             valid_n;
    logic             timeout_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [2:0]       cand;
    logic [2:0]       win;
    logic             win_found;
    logic             hold_hit;
    logic             owner_drop;

    assign state_dbg = (state == BUSY);

    // Rotating search: first requester after the last winner, wrapping 7 -> 0.
    always_comb begin
        cand      = '0;
        win       = last;
        win_found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = last + 3'(k);
            if (!win_found && req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    assign hold_hit   = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    assign owner_drop = !req[grant_idx];

    // Next state and next registered outputs.
    always_comb begin
        state_n   = state;
        last_n    = last;
        idx_n     = grant_idx;
        grant_n   = grant;
        valid_n   = grant_valid;
        timeout_n = 1'b0;
        cnt_n     = cnt;
        case (state)
            IDLE: begin
                if (en && win_found) begin
                    state_n = BUSY;
                    last_n  = win;
                    idx_n   = win;
                    grant_n = 8'b1 << win;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (release_req || owner_drop || hold_hit) begin
                    state_n   = IDLE;
                    grant_n   = '0;
                    valid_n   = 1'b0;
                    cnt_n     = '0;
                    // Only a pure expiry is reported; a voluntary end wins.
                    timeout_n = hold_hit && !release_req && !owner_drop;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                valid_n = 1'b0;
                cnt_n   = '0;
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 3'd7;
            grant_idx   <= 3'd0;
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            last        <= last_n;
            grant_idx   <= idx_n;
            grant       <= grant_n;
            grant_valid <= valid_n;
            timeout     <= timeout_n;
            cnt         <= cnt_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: directed scenarios plus randomized traffic,
// checked against a behavioural reference model and a grant scoreboard.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic       release_req = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    logic       state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .release_req (release_req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout),
        .state_dbg   (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: expected event did not occur at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Expected grant indices, pushed when the model decides a new grant.
    logic [2:0] exp_q[$];

    logic       m_busy = 1'b0;
    logic [2:0] m_idx  = 3'd0;
    logic [2:0] m_last = 3'd7;
    int         m_age  = 0;   // BUSY cycles already completed by the owner
    logic       m_to   = 1'b0;

    // Winner = first requester in the order last+1, last+2, ... modulo 8.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] l);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (int'(l) + k) % 8;
            if (r[i]) return 3'(i);
        end
        return l;
    endfunction

    logic m_rel, m_drop, m_hit;
    assign m_rel  = release_req;
    assign m_drop = !req[m_idx];
    assign m_hit  = (MAX_HOLD != 0) && (m_age + 1 == MAX_HOLD);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_idx  <= 3'd0;
            m_last <= 3'd7;
            m_age  <= 0;
            m_to   <= 1'b0;
            exp_q.delete();
        end else if (!m_busy) begin
            m_to <= 1'b0;
            if (en && req != 8'h00) begin
                exp_q.push_back(pick(req, m_last));
                m_idx  <= pick(req, m_last);
                m_last <= pick(req, m_last);
                m_busy <= 1'b1;
                m_age  <= 0;
            end
        end else begin
            if (m_rel || m_drop || m_hit) begin
                m_busy <= 1'b0;
                m_age  <= 0;
                m_to   <= m_hit && !m_rel && !m_drop;
            end else begin
                m_age <= m_age + 1;
                m_to  <= 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            check("grant_valid", {7'b0, grant_valid}, {7'b0, m_busy});
            check("timeout", {7'b0, timeout}, {7'b0, m_to});
            check("grant_idx", {5'b0, grant_idx}, {5'b0, m_idx});
            check("state_dbg", {7'b0, state_dbg}, {7'b0, m_busy});
            check("grant_decode", grant, m_busy ? (8'b1 << m_idx) : 8'h00);
            if (grant_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("grant_event_unexpected");
                end else begin
                    check("grant_event_idx", {5'b0, grant_idx}, {5'b0, exp_q[0]});
                    check("grant_event_onehot", grant, 8'b1 << exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            prev_valid <= grant_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        en          = 1'b0;
        req         = 8'h00;
        release_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        while (!grant_valid && c < 50) begin
            tick();
            c++;
        end
        if (!grant_valid) fail_now(name);
    endtask

    task automatic go_idle();
        req         = 8'h00;
        release_req = 1'b0;
        tick(3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g, bc, hi;
        logic pv;

        tick(3);
        check("reset_grant", grant, 8'h00);
        check("reset_idx", {5'b0, grant_idx}, 8'h00);
        check("reset_valid", {7'b0, grant_valid}, 8'h00);
        check("reset_timeout", {7'b0, timeout}, 8'h00);
        rst_n = 1'b1;
        tick();

        // Single requester, release, re-grant.
        en  = 1'b1;
        req = 8'b0000_0100;
        tick();
        check("t1_grant", grant, 8'h04);
        check("t1_idx", {5'b0, grant_idx}, 8'd2);
        check("t1_valid", {7'b0, grant_valid}, 8'd1);
        tick(3);
        release_req = 1'b1;
        tick();
        release_req = 1'b0;
        check("t1_release_grant", grant, 8'h00);
        tick();
        check("t1_regrant", grant, 8'h04);
        go_idle();

        // All requesting, release on every 2nd BUSY cycle.
        do_reset();
        en  = 1'b1;
        req = 8'hFF;
        g   = 0;
        bc  = 0;
        pv  = 1'b0;
        for (int c = 0; c < 200 && g < 9; c++) begin
            tick();
            if (grant_valid) begin
                if (!pv) begin
                    check("rot_idx", {5'b0, grant_idx}, 8'(g % 8));
                    g++;
                    bc = 0;
                end
                bc++;
                release_req = (bc == 2);
            end else begin
                release_req = 1'b0;
            end
            pv = grant_valid;
        end
        if (g < 9) fail_now("rot_sequence");
        go_idle();

        // Wrap past 7: owner 5 releases while 0 and 5 request.
        req = 8'h20;
        wait_valid("wrap_first");
        check("wrap_owner5", {5'b0, grant_idx}, 8'd5);
        release_req = 1'b1;
        req         = 8'h21;
        tick();
        release_req = 1'b0;
        tick();
        check("wrap_idx", {5'b0, grant_idx}, 8'd0);
        check("wrap_valid", {7'b0, grant_valid}, 8'd1);
        go_idle();

        // Hold timeout after MAX_HOLD cycles.
        req = 8'h08;
        wait_valid("to_first");
        hi = 0;
        for (int c = 0; c < 40 && grant_valid; c++) begin
            hi++;
            tick();
        end
        req = 8'h00;
        check("to_hold_cycles", 8'(hi), 8'(MAX_HOLD));
        check("to_pulse", {7'b0, timeout}, 8'd1);
        tick(3);

        // Release on the last permitted cycle suppresses the timeout.
        req = 8'h08;
        wait_valid("to_rel_first");
        tick(MAX_HOLD - 1);
        check("to_rel_still_valid", {7'b0, grant_valid}, 8'd1);
        release_req = 1'b1;
        tick();
        release_req = 1'b0;
        req         = 8'h00;
        check("to_rel_valid", {7'b0, grant_valid}, 8'd0);
        check("to_rel_timeout", {7'b0, timeout}, 8'd0);
        tick(3);

        // Owner 6 drops its request.
        req = 8'h40;
        wait_valid("drop_first");
        tick(2);
        req = 8'h00;
        tick();
        check("drop_grant", grant, 8'h00);
        check("drop_timeout", {7'b0, timeout}, 8'd0);
        tick(2);

        // Asynchronous reset mid-grant.
        req = 8'h10;
        wait_valid("arst_first");
        check("arst_pre_grant", grant, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant", grant, 8'h00);
        check("arst_valid", {7'b0, grant_valid}, 8'd0);
        tick(2);
        req   = 8'hFF;
        en    = 1'b1;
        rst_n = 1'b1;
        tick();
        check("arst_first_idx", {5'b0, grant_idx}, 8'd0);
        check("arst_first_valid", {7'b0, grant_valid}, 8'd1);
        go_idle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            tick();
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: req = 8'(1 << $urandom_range(0, 7));
                    1: req = 8'($urandom);
                    default: req = 8'hFF;
                endcase
            end
            release_req = ($urandom_range(0, 9) == 0);
        end
        en = 1'b1;
        go_idle();
        check("exp_q_drained", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
